// File: rtl/sd_xfer_sequencer_pkg.sv
// Shared types for the SD transfer sequencer: state encoding, error codes, CMD12 index.
// Included by the sequencer and by any block that decodes err_code.
package sd_xfer_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_CMD_ISSUE  = 4'd1,
    ST_CMD_WAIT   = 4'd2,
    ST_DATA_START = 4'd3,
    ST_DATA_WAIT  = 4'd4,
    ST_C12_ISSUE  = 4'd5,
    ST_C12_WAIT   = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERROR      = 4'd8
  } seq_state_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_CMD_TIMEOUT  = 3'd1,
    ERR_DATA_TIMEOUT = 3'd2,
    ERR_ZERO_BLK     = 3'd3,
    ERR_STOPPED      = 3'd4,
    ERR_C12_TIMEOUT  = 3'd5
  } seq_err_e;

  localparam logic [5:0] CMD12_INDEX = 6'd12;

  // Block counter never wraps below zero.
  function automatic logic [15:0] sat_dec(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

endpackage

// File: rtl/sd_xfer_sequencer_timeout_ctr.sv
// Clear/enable saturating cycle counter with a >= limit compare.
// One instance serves the response wait and the data wait; the limit is selected by the caller.
module sd_xfer_sequencer_timeout_ctr #(
  parameter int W = 17
) (
  input  logic         CLK,
  input  logic         rst_L,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      // NOTE: saturate instead of wrapping, so a stalled wait can never roll back under the limit.
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= limit);

endmodule

// File: rtl/sd_xfer_sequencer.sv
// Host-clock sequencer for one SD transaction: command, response, data blocks, optional auto CMD12,
// then a completion or error pulse. Auto CMD12 is compiled in with `define SD_SEQ_AUTO_CMD12_EN.
module sd_xfer_sequencer
  import sd_xfer_sequencer_pkg::*;
#(
  parameter int RESP_TIMEOUT = 1024,
  parameter int DATA_TIMEOUT = 65535,
  parameter int TO_W         = 17
) (
  input  logic        CLK,
  input  logic        rst_L,
  input  logic        start_flag,
  input  logic [5:0]  cmd_index,
  input  logic        data_present,
  input  logic        multiple_blk,
  input  logic [15:0] blk_cnt,
  input  logic        cmd_complete,
  input  logic        cmd_timeout,
  input  logic        blk_done,
  input  logic        stop,
  output logic        new_cmd,
  output logic [5:0]  cmd_index_out,
  output logic        cmd_arg_zero,
  output logic        dat_start,
  output logic        dma_start,
  output logic        seq_busy,
  output logic [15:0] blk_remaining,
  output logic        xfer_complete,
  output logic        err_irq,
  output logic [2:0]  err_code
);

  localparam logic [TO_W-1:0] RESP_LIM = TO_W'(RESP_TIMEOUT);
  localparam logic [TO_W-1:0] DATA_LIM = TO_W'(DATA_TIMEOUT);

  seq_state_e      state;
  logic            data_q;
  logic [15:0]     blk_next;
  logic            tmr_clr;
  logic            tmr_en;
  logic [TO_W-1:0] tmr_limit;
  logic            tmr_expired;

`ifdef SD_SEQ_AUTO_CMD12_EN
  logic            multi_q;
  logic            via_stop_q;
`else
  logic            unused_multi;
  assign unused_multi = multiple_blk;
`endif

  assign blk_next = blk_done ? sat_dec(blk_remaining) : blk_remaining;

  // Timer restarts on each issue/launch state and on every finished block.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    tmr_limit = RESP_LIM;
    case (state)
      ST_CMD_ISSUE, ST_DATA_START, ST_C12_ISSUE: tmr_clr = 1'b1;
      ST_CMD_WAIT, ST_C12_WAIT:                  tmr_en  = 1'b1;
      ST_DATA_WAIT: begin
        tmr_clr   = blk_done;
        tmr_en    = 1'b1;
        tmr_limit = DATA_LIM;
      end
      default: ;
    endcase
  end

  sd_xfer_sequencer_timeout_ctr #(
    .W(TO_W)
  ) u_timeout_ctr (
    .CLK     (CLK),
    .rst_L   (rst_L),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      state         <= ST_IDLE;
      new_cmd       <= 1'b0;
      cmd_index_out <= '0;
      cmd_arg_zero  <= 1'b0;
      dat_start     <= 1'b0;
      dma_start     <= 1'b0;
      seq_busy      <= 1'b0;
      blk_remaining <= '0;
      xfer_complete <= 1'b0;
      err_irq       <= 1'b0;
      err_code      <= ERR_NONE;
      data_q        <= 1'b0;
`ifdef SD_SEQ_AUTO_CMD12_EN
      multi_q       <= 1'b0;
      via_stop_q    <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low each cycle; a state sets them on entry so each is one cycle wide.
      new_cmd       <= 1'b0;
      cmd_arg_zero  <= 1'b0;
      dat_start     <= 1'b0;
      dma_start     <= 1'b0;
      xfer_complete <= 1'b0;
      err_irq       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_flag) begin
            state         <= ST_CMD_ISSUE;
            new_cmd       <= 1'b1;
            cmd_index_out <= cmd_index;
            blk_remaining <= blk_cnt;
            data_q        <= data_present;
            err_code      <= ERR_NONE;
            seq_busy      <= 1'b1;
`ifdef SD_SEQ_AUTO_CMD12_EN
            multi_q       <= multiple_blk;
`endif
          end
        end

        ST_CMD_ISSUE: begin
          if (stop) begin
            state    <= ST_ERROR;
            err_irq  <= 1'b1;
            err_code <= ERR_STOPPED;
          end else begin
            state <= ST_CMD_WAIT;
          end
        end

        ST_CMD_WAIT: begin
          if (cmd_timeout || tmr_expired) begin
            state    <= ST_ERROR;
            err_irq  <= 1'b1;
            err_code <= ERR_CMD_TIMEOUT;
          end else if (stop) begin
            state    <= ST_ERROR;
            err_irq  <= 1'b1;
            err_code <= ERR_STOPPED;
          end else if (cmd_complete) begin
            if (data_q) begin
              // Strobe decided on entry so it is high during DATA_START itself.
              state     <= ST_DATA_START;
              dat_start <= (blk_remaining != 16'd0);
              dma_start <= (blk_remaining != 16'd0);
            end else begin
              state         <= ST_DONE;
              xfer_complete <= 1'b1;
            end
          end
        end

        ST_DATA_START: begin
          if (blk_remaining == 16'd0) begin
            state    <= ST_ERROR;
            err_irq  <= 1'b1;
            err_code <= ERR_ZERO_BLK;
          end else begin
            state <= ST_DATA_WAIT;
          end
        end

        ST_DATA_WAIT: begin
          blk_remaining <= blk_next;
          if (stop) begin
`ifdef SD_SEQ_AUTO_CMD12_EN
            state         <= ST_C12_ISSUE;
            new_cmd       <= 1'b1;
            cmd_index_out <= CMD12_INDEX;
            cmd_arg_zero  <= 1'b1;
            via_stop_q    <= 1'b1;
`else
            state    <= ST_ERROR;
            err_irq  <= 1'b1;
            err_code <= ERR_STOPPED;
`endif
          end else if (blk_done && (blk_next == 16'd0)) begin
`ifdef SD_SEQ_AUTO_CMD12_EN
            if (multi_q) begin
              state         <= ST_C12_ISSUE;
              new_cmd       <= 1'b1;
              cmd_index_out <= CMD12_INDEX;
              cmd_arg_zero  <= 1'b1;
              via_stop_q    <= 1'b0;
            end else begin
              state         <= ST_DONE;
              xfer_complete <= 1'b1;
            end
`else
            state         <= ST_DONE;
            xfer_complete <= 1'b1;
`endif
          end else if (!blk_done && tmr_expired) begin
            state    <= ST_ERROR;
            err_irq  <= 1'b1;
            err_code <= ERR_DATA_TIMEOUT;
          end
        end

`ifdef SD_SEQ_AUTO_CMD12_EN
        ST_C12_ISSUE: begin
          state <= ST_C12_WAIT;
        end

        // A stop-initiated CMD12 still ends as an error even when the response arrives.
        ST_C12_WAIT: begin
          if (cmd_timeout || tmr_expired) begin
            state    <= ST_ERROR;
            err_irq  <= 1'b1;
            err_code <= ERR_C12_TIMEOUT;
          end else if (cmd_complete) begin
            if (via_stop_q) begin
              state    <= ST_ERROR;
              err_irq  <= 1'b1;
              err_code <= ERR_STOPPED;
            end else begin
              state         <= ST_DONE;
              xfer_complete <= 1'b1;
            end
          end
        end
`endif

        ST_DONE, ST_ERROR: begin
          state    <= ST_IDLE;
          seq_busy <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          seq_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_xfer_sequencer.sv
// Directed bench for sd_xfer_sequencer: each scenario builds a per-cycle stimulus table and an expected
// output timeline from transaction-level rules; one negedge process compares every cycle.
module tb_sd_xfer_sequencer;

  localparam int RESP_TO = 1024;
  localparam int DATA_TO = 50;
  localparam int N       = 1100;
`ifdef SD_SEQ_AUTO_CMD12_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct packed {
    logic        rst_l;
    logic        start;
    logic [5:0]  idx;
    logic        dp;
    logic        mb;
    logic [15:0] bc;
    logic        cc;
    logic        ct;
    logic        bd;
    logic        stop;
  } stim_t;

  typedef struct packed {
    logic        new_cmd;
    logic        idx_chk;
    logic [5:0]  idx;
    logic        az;
    logic        dat;
    logic        busy;
    logic [15:0] rem;
    logic        xc;
    logic        ei;
    logic [2:0]  ec;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rst_L;
  logic        start_flag;
  logic [5:0]  cmd_index;
  logic        data_present;
  logic        multiple_blk;
  logic [15:0] blk_cnt;
  logic        cmd_complete;
  logic        cmd_timeout;
  logic        blk_done;
  logic        stop;
  logic        new_cmd;
  logic [5:0]  cmd_index_out;
  logic        cmd_arg_zero;
  logic        dat_start;
  logic        dma_start;
  logic        seq_busy;
  logic [15:0] blk_remaining;
  logic        xfer_complete;
  logic        err_irq;
  logic [2:0]  err_code;

  stim_t st [N];
  exp_t  ex [N];
  int    bdq [$];
  int    checks;
  int    errors;
  int    cyc;
  bit    active;
  int    first_new, first_xc, first_ei, n_new, n_dat;
  int    end_t;

  sd_xfer_sequencer #(
    .RESP_TIMEOUT (RESP_TO),
    .DATA_TIMEOUT (DATA_TO),
    .TO_W         (17)
  ) dut (
    .CLK           (CLK),
    .rst_L         (rst_L),
    .start_flag    (start_flag),
    .cmd_index     (cmd_index),
    .data_present  (data_present),
    .multiple_blk  (multiple_blk),
    .blk_cnt       (blk_cnt),
    .cmd_complete  (cmd_complete),
    .cmd_timeout   (cmd_timeout),
    .blk_done      (blk_done),
    .stop          (stop),
    .new_cmd       (new_cmd),
    .cmd_index_out (cmd_index_out),
    .cmd_arg_zero  (cmd_arg_zero),
    .dat_start     (dat_start),
    .dma_start     (dma_start),
    .seq_busy      (seq_busy),
    .blk_remaining (blk_remaining),
    .xfer_complete (xfer_complete),
    .err_irq       (err_irq),
    .err_code      (err_code)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  // Per-cycle comparison against the expected timeline.
  always @(negedge CLK) begin
    if (active) begin
      check("new_cmd",       32'(new_cmd),       32'(ex[cyc].new_cmd));
      check("cmd_arg_zero",  32'(cmd_arg_zero),  32'(ex[cyc].az));
      check("dat_start",     32'(dat_start),     32'(ex[cyc].dat));
      check("dma_start",     32'(dma_start),     32'(ex[cyc].dat));
      check("seq_busy",      32'(seq_busy),      32'(ex[cyc].busy));
      check("blk_remaining", 32'(blk_remaining), 32'(ex[cyc].rem));
      check("xfer_complete", 32'(xfer_complete), 32'(ex[cyc].xc));
      check("err_irq",       32'(err_irq),       32'(ex[cyc].ei));
      check("err_code",      32'(err_code),      32'(ex[cyc].ec));
      if (ex[cyc].idx_chk)
        check("cmd_index_out", 32'(cmd_index_out), 32'(ex[cyc].idx));
      if (new_cmd === 1'b1) begin
        n_new++;
        if (first_new < 0) first_new = cyc;
      end
      if (dat_start === 1'b1) n_dat++;
      if (xfer_complete === 1'b1 && first_xc < 0) first_xc = cyc;
      if (err_irq === 1'b1 && first_ei < 0) first_ei = cyc;
    end
  end

  task automatic clr_scn(input int rem0, input int ec0);
    for (int i = 0; i < N; i++) begin
      st[i]       = '0;
      st[i].rst_l = 1'b1;
      ex[i]       = '0;
      ex[i].rem   = 16'(rem0);
      ex[i].ec    = 3'(ec0);
    end
    bdq.delete();
    first_new = -1; first_xc = -1; first_ei = -1; n_new = 0; n_dat = 0;
  endtask

  task automatic s_start(input int t, input int idx, input bit dp, input bit mb, input int bc);
    st[t].start = 1'b1;
    for (int i = t; i < N; i++) begin
      st[i].idx = 6'(idx);
      st[i].dp  = dp;
      st[i].mb  = mb;
      st[i].bc  = 16'(bc);
    end
  endtask

  task automatic e_cmd(input int t, input int idx, input bit az);
    ex[t].new_cmd = 1'b1;
    ex[t].idx_chk = 1'b1;
    ex[t].idx     = 6'(idx);
    ex[t].az      = az;
  endtask

  task automatic e_rem(input int t, input int v);
    for (int i = t; i < N; i++) ex[i].rem = 16'(v);
  endtask

  task automatic e_ec(input int t, input int v);
    for (int i = t; i < N; i++) ex[i].ec = 3'(v);
  endtask

  task automatic e_busy(input int t0, input int t1);
    for (int i = t0; i <= t1; i++) ex[i].busy = 1'b1;
  endtask

  // Transaction model of a run that succeeds (or fails only on zero block count):
  // command strobe one cycle after start, end pulse one cycle after the deciding input.
  task automatic model_xfer(input int s, input int idx, input int bc, input bit dp, input bit mb,
                            input int r, input int c12r, output int fin);
    int rem;
    s_start(s, idx, dp, mb, bc);
    st[r].cc = 1'b1;
    e_cmd(s + 1, idx, 1'b0);
    e_rem(s + 1, bc);
    e_ec(s + 1, 0);
    if (!dp) begin
      fin = r + 1;
      ex[fin].xc = 1'b1;
    end else if (bc == 0) begin
      fin = r + 2;
      ex[fin].ei = 1'b1;
      e_ec(fin, 3);
    end else begin
      ex[r + 1].dat = 1'b1;
      rem = bc;
      fin = r + 2;
      foreach (bdq[k]) begin
        st[bdq[k]].bd = 1'b1;
        rem--;
        e_rem(bdq[k] + 1, rem);
        fin = bdq[k] + 1;
      end
      if (mb && AUTO) begin
        e_cmd(fin, 12, 1'b1);
        st[c12r].cc = 1'b1;
        fin = c12r + 1;
      end
      ex[fin].xc = 1'b1;
    end
    e_busy(s + 1, fin);
  endtask

  task automatic run(input int len);
    active = 1'b1;
    for (int t = 0; t < len; t++) begin
      cyc          = t;
      rst_L        = st[t].rst_l;
      start_flag   = st[t].start;
      cmd_index    = st[t].idx;
      data_present = st[t].dp;
      multiple_blk = st[t].mb;
      blk_cnt      = st[t].bc;
      cmd_complete = st[t].cc;
      cmd_timeout  = st[t].ct;
      blk_done     = st[t].bd;
      stop         = st[t].stop;
      @(posedge CLK);
      #1;
    end
    active = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; active = 1'b0; cyc = 0;
    rst_L = 1'b0; start_flag = 1'b0; cmd_index = '0; data_present = 1'b0; multiple_blk = 1'b0;
    blk_cnt = '0; cmd_complete = 1'b0; cmd_timeout = 1'b0; blk_done = 1'b0; stop = 1'b0;
    @(posedge CLK);
    #1;

    // Reset state
    clr_scn(0, 0);
    for (int t = 0; t < 3; t++) st[t].rst_l = 1'b0;
    for (int t = 0; t < 5; t++) ex[t].idx_chk = 1'b1;
    run(5);

    // Command without data: response 5 cycles after start
    clr_scn(0, 0);
    model_xfer(1, 17, 7, 1'b0, 1'b0, 6, 0, end_t);
    run(end_t + 3);
    check("s1_new_cmd_cycle", first_new, 2);
    check("s1_xfer_complete_cycle", first_xc, 7);

    // Multi-block read of 3 blocks, auto CMD12 when compiled in
    clr_scn(7, 0);
    bdq = {9, 12, 15};
    model_xfer(1, 18, 3, 1'b1, 1'b1, 5, 20, end_t);
    run(end_t + 3);
    check("s2_done_cycle", first_xc, AUTO ? 21 : 16);
    check("s2_cmd_strobes", n_new, AUTO ? 2 : 1);

    // Response timeout
    clr_scn(0, 0);
    s_start(1, 5, 1'b0, 1'b0, 5);
    e_cmd(2, 5, 1'b0);
    e_rem(2, 5);
    e_busy(2, 1 + RESP_TO + 3);
    ex[1 + RESP_TO + 3].ei = 1'b1;
    e_ec(1 + RESP_TO + 3, 1);
    run(1 + RESP_TO + 7);
    check("s3_err_irq_cycle", first_ei, 1028);

    // Response and timeout together: timeout wins; err_code held until this start clears it
    clr_scn(5, 1);
    s_start(1, 8, 1'b0, 1'b0, 2);
    st[4].cc = 1'b1;
    st[4].ct = 1'b1;
    e_cmd(2, 8, 1'b0);
    e_rem(2, 2);
    e_ec(2, 0);
    e_busy(2, 5);
    ex[5].ei = 1'b1;
    e_ec(5, 1);
    run(8);

    // Zero block count with a data phase
    clr_scn(2, 1);
    model_xfer(1, 24, 0, 1'b1, 1'b0, 4, 0, end_t);
    run(end_t + 3);
    check("s5_dat_strobes", n_dat, 0);
    check("s5_err_code", 32'(err_code), 3);

    // Stop together with blk_done at two blocks left
    clr_scn(0, 3);
    s_start(1, 18, 1'b1, 1'b1, 3);
    e_cmd(2, 18, 1'b0);
    e_rem(2, 3);
    e_ec(2, 0);
    st[3].cc = 1'b1;
    ex[4].dat = 1'b1;
    st[6].bd = 1'b1;
    e_rem(7, 2);
    st[8].bd = 1'b1;
    for (int t = 8; t <= 12; t++) st[t].stop = 1'b1;
    e_rem(9, 1);
    if (AUTO) begin
      e_cmd(9, 12, 1'b1);
      st[12].cc = 1'b1;
      end_t = 13;
    end else begin
      end_t = 9;
    end
    e_busy(2, end_t);
    ex[end_t].ei = 1'b1;
    e_ec(end_t, 4);
    run(17);

    // Starts while busy are ignored; async reset in the data phase
    clr_scn(1, 4);
    s_start(1, 25, 1'b1, 1'b0, 2);
    st[3].start = 1'b1;
    st[8].start = 1'b1;
    st[4].cc = 1'b1;
    st[7].bd = 1'b1;
    st[10].rst_l = 1'b0;
    st[11].rst_l = 1'b0;
    st[13].bd = 1'b1;
    e_cmd(2, 25, 1'b0);
    e_rem(2, 2);
    e_ec(2, 0);
    ex[5].dat = 1'b1;
    e_rem(8, 1);
    e_busy(2, 9);
    e_rem(10, 0);
    ex[10].idx_chk = 1'b1;
    ex[10].idx = '0;
    run(16);
    check("s7_cmd_strobes", n_new, 1);

    // Data timeout measured from the last finished block
    clr_scn(0, 0);
    s_start(1, 9, 1'b1, 1'b1, 2);
    st[3].cc = 1'b1;
    st[7].bd = 1'b1;
    e_cmd(2, 9, 1'b0);
    e_rem(2, 2);
    ex[4].dat = 1'b1;
    e_rem(8, 1);
    e_busy(2, 9 + DATA_TO);
    ex[9 + DATA_TO].ei = 1'b1;
    e_ec(9 + DATA_TO, 2);
    run(13 + DATA_TO);
    check("s8_err_irq_cycle", first_ei, 59);

    // Stop while waiting for the response
    clr_scn(1, 2);
    s_start(1, 3, 1'b0, 1'b0, 1);
    st[3].stop = 1'b1;
    e_cmd(2, 3, 1'b0);
    e_ec(2, 0);
    e_busy(2, 4);
    ex[4].ei = 1'b1;
    e_ec(4, 4);
    run(7);

    // Single block, not multi: no CMD12 in either build
    clr_scn(1, 4);
    bdq = {8};
    model_xfer(1, 17, 1, 1'b1, 1'b0, 4, 0, end_t);
    run(end_t + 3);
    check("s10_done_cycle", first_xc, 9);
    check("s10_cmd_strobes", n_new, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
